axi_lite_mem_responder: RTL



---
 rtl/axi_lite_mem_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_responder.sv
// axi_lite_mem_responder
//
// Purpose: single-beat AXI-Lite slave backed by a word-addressed memory of
// MEM_DEPTH x DATA_WIDTH bits starting at byte address BASE_ADDR. One
// transaction is served at a time. Every response is delayed by a programmable
// number of wait cycles, so b_valid_o / r_valid_o rise LATENCY+1 cycles after
// the W / AR handshake edge. Addresses outside the window get SLVERR and have
// no effect on memory.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   aw_valid_i/aw_ready_o/aw_addr_i  write address channel
//   w_valid_i/w_ready_o/w_data_i/w_strb_i  write data channel
//   b_valid_o/b_ready_i/b_resp_o     write response channel
//   ar_valid_i/ar_ready_o/ar_addr_i  read address channel
//   r_valid_o/r_ready_i/r_resp_o/r_data_o  read data channel
//
// state | meaning
// IDLE  | both address channels ready; a write wins over a simultaneous read
// WDATA | write address latched, waiting for the W beat
// WWAIT | write done, counting down the response delay
// BRESP | write response presented until b_ready_i
// RWAIT | read address latched, counting down the response delay
// RRESP | read data/response presented until r_ready_i

module axi_lite_mem_responder #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,

  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,

  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [1:0]              b_resp_o,

  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,

  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [1:0]              r_resp_o,
  output logic [DATA_WIDTH-1:0]   r_data_o
);

  localparam int                  STRB_W    = DATA_WIDTH / 8;
  localparam int                  IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 8);
  localparam logic [3:0]          LAT_CNT   = 4'(LATENCY);
  localparam logic [1:0]          RESP_OKAY = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WWAIT,
    BRESP,
    RWAIT,
    RRESP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [IDX_W-1:0]        r_idx;
  logic                    r_in_range;
  logic [3:0]              r_cnt;
  logic [1:0]              r_b_resp;
  logic [1:0]              r_r_resp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]   w_req_addr;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;

  logic                    w_aw_ready;
  logic                    w_ar_ready;
  logic                    w_w_ready;
  logic                    w_b_valid;
  logic                    w_r_valid;
  logic                    w_aw_fire;
  logic                    w_ar_fire;
  logic                    w_w_fire;

  // A single decoder serves both address channels; the write address wins
  // whenever aw_valid_i is high, matching the IDLE arbitration.
  assign w_req_addr = aw_valid_i ? aw_addr_i : ar_addr_i;
  assign w_offset   = w_req_addr - BASE_ADDR;
  // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets.
  assign w_in_range = ({1'b0, w_offset} < MEM_BYTES);
  assign w_idx      = w_offset[IDX_W+2:3];

  assign w_aw_fire = (r_state == IDLE) && aw_valid_i;
  assign w_ar_fire = (r_state == IDLE) && !aw_valid_i && ar_valid_i;
  assign w_w_fire  = (r_state == WDATA) && w_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_aw_ready  = 1'b0;
    w_ar_ready  = 1'b0;
    w_w_ready   = 1'b0;
    w_b_valid   = 1'b0;
    w_r_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        w_aw_ready = 1'b1;
        w_ar_ready = 1'b1;
        if (aw_valid_i) begin
          w_state_nxt = WDATA;
        end else if (ar_valid_i) begin
          w_state_nxt = RWAIT;
        end
      end
      WDATA: begin
        w_w_ready = 1'b1;
        if (w_valid_i) begin
          w_state_nxt = WWAIT;
        end
      end
      // The wait state is always visited so the response lands exactly
      // LATENCY+1 edges after the handshake, including LATENCY=0.
      WWAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = BRESP;
        end
      end
      BRESP: begin
        w_b_valid = 1'b1;
        if (b_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      RWAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RRESP;
        end
      end
      RRESP: begin
        w_r_valid = 1'b1;
        if (r_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_cnt      <= 4'd0;
      r_b_resp   <= 2'b00;
      r_r_resp   <= 2'b00;
      r_rdata    <= '0;
    end else begin
      if (w_aw_fire || w_ar_fire) begin
        r_idx      <= w_idx;
        r_in_range <= w_in_range;
      end
      if (w_ar_fire || w_w_fire) begin
        r_cnt <= LAT_CNT;
      end else if ((r_state == WWAIT) || (r_state == RWAIT)) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if ((r_state == WWAIT) && (r_cnt == 4'd0)) begin
        r_b_resp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      // Memory is sampled on the edge that enters RRESP, so the data reflects
      // the array contents of the last wait cycle.
      if ((r_state == RWAIT) && (r_cnt == 4'd0)) begin
        r_r_resp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        r_rdata  <= r_in_range ? r_mem[r_idx] : '0;
      end
    end
  end

  // Storage is deliberately not reset; rst only blocks a write on its edge.
  always_ff @(posedge clk) begin
    if (!rst && w_w_fire && r_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) begin
          r_mem[r_idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign aw_ready_o = w_aw_ready;
  assign ar_ready_o = w_ar_ready;
  assign w_ready_o  = w_w_ready;
  assign b_valid_o  = w_b_valid;
  assign r_valid_o  = w_r_valid;
  assign b_resp_o   = r_b_resp;
  assign r_resp_o   = r_r_resp;
  assign r_data_o   = r_rdata;

endmodule
